// File: rtl/clock_bcd_counter.sv
// HH:MM:SS timekeeping core: TICK_DIV prescaler, six BCD digits, push-button set mode.
// Define H12_EN for 12-hour mode with PM flag; default build is 24-hour mode.
module clock_bcd_counter #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       set_en,
    input  logic [1:0] set_sel,
    input  logic       inc,
    output logic [3:0] sec_lo,
    output logic [3:0] sec_hi,
    output logic [3:0] min_lo,
    output logic [3:0] min_hi,
    output logic [3:0] hr_lo,
    output logic [3:0] hr_hi,
    output logic       tick,
    output logic       day_roll,
    output logic       pm
);
    localparam int unsigned DW = $clog2(TICK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
`ifdef H12_EN
    localparam logic [3:0] HR_HI_RST = 4'd1;
    localparam logic [3:0] HR_LO_RST = 4'd2;
`else
    localparam logic [3:0] HR_HI_RST = 4'd0;
    localparam logic [3:0] HR_LO_RST = 4'd0;
`endif

    // Next value of a 00..59 BCD pair as {wrap, hi, lo}.
    function automatic logic [8:0] step_60(input logic [3:0] hi, input logic [3:0] lo);
        logic [8:0] r;
        if (lo != 4'd9) begin
            r = {1'b0, hi, lo + 4'd1};
        end else if (hi != 4'd5) begin
            r = {1'b0, hi + 4'd1, 4'd0};
        end else begin
            r = {1'b1, 4'd0, 4'd0};
        end
        return r;
    endfunction

    // Next hour as {pm_toggle, day_wrap, hi, lo}.
    function automatic logic [9:0] step_hr(input logic [3:0] hi, input logic [3:0] lo);
        logic [9:0] r;
`ifdef H12_EN
        if (hi == 4'd1 && lo == 4'd2) begin
            r = {1'b0, 1'b0, 4'd0, 4'd1};
        end else if (hi == 4'd1 && lo == 4'd1) begin
            r = {1'b1, 1'b0, 4'd1, 4'd2};
        end else if (lo == 4'd9) begin
            r = {1'b0, 1'b0, hi + 4'd1, 4'd0};
        end else begin
            r = {1'b0, 1'b0, hi, lo + 4'd1};
        end
`else
        if (hi == 4'd2 && lo == 4'd3) begin
            r = {1'b0, 1'b1, 4'd0, 4'd0};
        end else if (lo == 4'd9) begin
            r = {1'b0, 1'b0, hi + 4'd1, 4'd0};
        end else begin
            r = {1'b0, 1'b0, hi, lo + 4'd1};
        end
`endif
        return r;
    endfunction

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]    sec_lo_q, sec_lo_d, sec_hi_q, sec_hi_d;
    logic [3:0]    min_lo_q, min_lo_d, min_hi_q, min_hi_d;
    logic [3:0]    hr_lo_q, hr_lo_d, hr_hi_q, hr_hi_d;
    logic          tick_q, tick_d, day_roll_q, day_roll_d, pm_q, pm_d;
    logic [8:0]    sec_nx_s, min_nx_s;
    logic [9:0]    hr_nx_s;

    assign sec_nx_s = step_60(sec_hi_q, sec_lo_q);
    assign min_nx_s = step_60(min_hi_q, min_lo_q);
    assign hr_nx_s  = step_hr(hr_hi_q, hr_lo_q);

    // Next-state: set mode takes precedence over timekeeping; carries resolve in one edge.
    always_comb begin
        div_cnt_d  = div_cnt_q;
        sec_lo_d   = sec_lo_q;
        sec_hi_d   = sec_hi_q;
        min_lo_d   = min_lo_q;
        min_hi_d   = min_hi_q;
        hr_lo_d    = hr_lo_q;
        hr_hi_d    = hr_hi_q;
        pm_d       = pm_q;
        tick_d     = 1'b0;
        day_roll_d = 1'b0;
        if (set_en) begin
            div_cnt_d = '0;
            sec_lo_d  = 4'd0;
            sec_hi_d  = 4'd0;
            case ({inc, set_sel})
                3'b100: begin
                    min_hi_d = min_nx_s[7:4];
                    min_lo_d = min_nx_s[3:0];
                end
                3'b101: begin
                    hr_hi_d = hr_nx_s[7:4];
                    hr_lo_d = hr_nx_s[3:0];
                    pm_d    = pm_q ^ hr_nx_s[9];
                end
                default: begin
                    min_lo_d = min_lo_q;
                end
            endcase
        end else if (run) begin
            if (div_cnt_q == DIV_LAST) begin
                div_cnt_d = '0;
                tick_d    = 1'b1;
                sec_hi_d  = sec_nx_s[7:4];
                sec_lo_d  = sec_nx_s[3:0];
                if (sec_nx_s[8]) begin
                    min_hi_d = min_nx_s[7:4];
                    min_lo_d = min_nx_s[3:0];
                    if (min_nx_s[8]) begin
                        hr_hi_d    = hr_nx_s[7:4];
                        hr_lo_d    = hr_nx_s[3:0];
                        pm_d       = pm_q ^ hr_nx_s[9];
                        // 12 h: the day ends when PM falls back to AM.
                        day_roll_d = hr_nx_s[8] | (hr_nx_s[9] & pm_q);
                    end else begin
                        hr_lo_d = hr_lo_q;
                    end
                end else begin
                    min_lo_d = min_lo_q;
                end
            end else begin
                div_cnt_d = div_cnt_q + DW'(1);
            end
        end else begin
            div_cnt_d = div_cnt_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q  <= '0;
            sec_lo_q   <= 4'd0;
            sec_hi_q   <= 4'd0;
            min_lo_q   <= 4'd0;
            min_hi_q   <= 4'd0;
            hr_lo_q    <= HR_LO_RST;
            hr_hi_q    <= HR_HI_RST;
            tick_q     <= 1'b0;
            day_roll_q <= 1'b0;
            pm_q       <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            sec_lo_q   <= sec_lo_d;
            sec_hi_q   <= sec_hi_d;
            min_lo_q   <= min_lo_d;
            min_hi_q   <= min_hi_d;
            hr_lo_q    <= hr_lo_d;
            hr_hi_q    <= hr_hi_d;
            tick_q     <= tick_d;
            day_roll_q <= day_roll_d;
            pm_q       <= pm_d;
        end
    end

    assign sec_lo   = sec_lo_q;
    assign sec_hi   = sec_hi_q;
    assign min_lo   = min_lo_q;
    assign min_hi   = min_hi_q;
    assign hr_lo    = hr_lo_q;
    assign hr_hi    = hr_hi_q;
    assign tick     = tick_q;
    assign day_roll = day_roll_q;
    assign pm       = pm_q;
endmodule

// File: tb/tb_clock_bcd_counter.sv
// Directed bench for clock_bcd_counter with TICK_DIV=4; expectations follow H12_EN when defined.
module tb_clock_bcd_counter;
    localparam int TD = 4;
`ifdef H12_EN
    localparam logic [7:0] HR0 = 8'h12;
`else
    localparam logic [7:0] HR0 = 8'h00;
`endif

    logic       clk = 1'b0;
    logic       rst, run, set_en, inc;
    logic [1:0] set_sel;
    logic [3:0] sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi;
    logic       tick, day_roll, pm;

    int checks = 0;
    int errors = 0;
    int n_tick, n_roll, roll_on_tick, gap_err, prev_t, set_ticks, c;
    logic [23:0] t_snap;

    clock_bcd_counter #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .run(run), .set_en(set_en), .set_sel(set_sel), .inc(inc),
        .sec_lo(sec_lo), .sec_hi(sec_hi), .min_lo(min_lo), .min_hi(min_hi),
        .hr_lo(hr_lo), .hr_hi(hr_hi), .tick(tick), .day_roll(day_roll), .pm(pm)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] now_t();
        return {hr_hi, hr_lo, min_hi, min_lo, sec_hi, sec_lo};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_for(input int n);
        n_tick = 0; n_roll = 0; roll_on_tick = 0; gap_err = 0; prev_t = 0;
        for (int i = 1; i <= n; i++) begin
            cyc();
            if (tick) begin
                n_tick++;
                if (i - prev_t != TD) gap_err++;
                prev_t = i;
            end
            if (day_roll) begin
                n_roll++;
                if (tick && n_tick == 60) roll_on_tick++;
            end
        end
    endtask

    task automatic incs(input int k);
        inc = 1'b1;
        for (int i = 0; i < k; i++) begin
            cyc();
            if (tick) set_ticks++;
        end
        inc = 1'b0;
    endtask

    task automatic wait_tick(output int cnt);
        cnt = 0;
        do begin
            cyc();
            cnt++;
        end while (!tick && cnt < 20);
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; set_en = 1'b0; set_sel = 2'd0; inc = 1'b0;
        set_ticks = 0;
        cyc(); cyc();
        check("rst_time", 32'(now_t()), {8'h00, HR0, 16'h0000});
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_roll", 32'(day_roll), 32'd0);
        check("rst_pm", 32'(pm), 32'd0);
        rst = 1'b0;

        run = 1'b1;
        run_for(240);
        check("run_ticks", n_tick, 60);
        check("run_gap", gap_err, 0);
        check("run_time", 32'(now_t()), {8'h00, HR0, 16'h0100});
        check("run_roll", n_roll, 0);

        run_for(6);
        rst = 1'b1;
        cyc();
        check("midrst_time", 32'(now_t()), {8'h00, HR0, 16'h0000});
        check("midrst_tick", 32'(tick), 32'd0);
        rst = 1'b0; run = 1'b0;

        set_en = 1'b1; set_sel = 2'd1;
        incs(23);
`ifdef H12_EN
        check("set_hr", 32'(now_t()), 32'h110000);
        check("set_hr_pm", 32'(pm), 32'd1);
`else
        check("set_hr", 32'(now_t()), 32'h230000);
        check("set_hr_pm", 32'(pm), 32'd0);
`endif
        set_sel = 2'd0;
        incs(59);
`ifdef H12_EN
        check("set_min", 32'(now_t()), 32'h115900);
`else
        check("set_min", 32'(now_t()), 32'h235900);
`endif
        check("set_noroll", 32'(day_roll), 32'd0);
        set_en = 1'b0; run = 1'b1;
        run_for(240);
        check("day_ticks", n_tick, 60);
        check("day_rolls", n_roll, 1);
        check("day_roll_at_tick60", roll_on_tick, 1);
        check("day_time", 32'(now_t()), {8'h00, HR0, 16'h0000});
        check("day_pm", 32'(pm), 32'd0);

        run_for(10);
        check("pre_set_time", 32'(now_t()), {8'h00, HR0, 16'h0002});
        run = 1'b0; set_en = 1'b1; set_sel = 2'd0;
        incs(61);
        check("min_wrap", 32'(now_t()), {8'h00, HR0, 16'h0100});
        set_sel = 2'd2;
        incs(5);
        set_sel = 2'd3;
        incs(3);
        check("sel_none", 32'(now_t()), {8'h00, HR0, 16'h0100});
        check("set_no_tick", set_ticks, 0);

        set_en = 1'b0; run = 1'b1;
        wait_tick(c);
        check("resume_lat", c, TD);
        check("resume_time", 32'(now_t()), {8'h00, HR0, 16'h0101});

        cyc(); cyc();
        t_snap = now_t();
        run = 1'b0;
        n_tick = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (tick) n_tick++;
        end
        check("hold_time", 32'(now_t()), 32'(t_snap));
        check("hold_ticks", n_tick, 0);
        run = 1'b1;
        wait_tick(c);
        check("hold_phase", c, 2);
        check("hold_after", 32'(now_t()), {8'h00, HR0, 16'h0102});

        cyc(); cyc(); cyc();
        set_en = 1'b1;
        cyc();
        check("wrap_vs_set_tick", 32'(tick), 32'd0);
        check("wrap_vs_set_time", 32'(now_t()), {8'h00, HR0, 16'h0100});
        set_en = 1'b0;
        wait_tick(c);
        check("wrap_vs_set_lat", c, TD);

`ifdef H12_EN
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0; run = 1'b0;
        check("h12_rst", 32'(now_t()), 32'h120000);
        check("h12_rst_pm", 32'(pm), 32'd0);
        set_en = 1'b1; set_sel = 2'd1;
        incs(11);
        check("h12_set_hr", 32'(now_t()), 32'h110000);
        check("h12_set_pm", 32'(pm), 32'd0);
        set_sel = 2'd0;
        incs(59);
        set_en = 1'b0; run = 1'b1;
        run_for(240);
        check("h12_noon", 32'(now_t()), 32'h120000);
        check("h12_noon_pm", 32'(pm), 32'd1);
        check("h12_noon_roll", n_roll, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
